// File: rtl/raise_freq.sv
// Frequency-domain pitch raise: ping-pong buffers two FFT channels, then streams each
// frame shifted up by SHIFT bins with the two channels averaged.
module raise_freq #(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned NBIN  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fft1_data,
  input  logic        fft1_valid,
  input  logic [5:0]  freq1,
  input  logic        fft1_fin,
  input  logic [31:0] fft2_data,
  input  logic        fft2_valid,
  input  logic [5:0]  freq2,
  input  logic        fft2_fin,
  output logic [31:0] raise_data,
  output logic        raise_valid,
  output logic [5:0]  freq_out,
  output logic        raise_fin
);

  localparam logic [5:0] ShiftBins = 6'(SHIFT);
  localparam logic [5:0] LastBin   = 6'(NBIN - 1);

  // Address is {bank, bin}; bank selects the ping-pong half.
  logic [31:0] bank1 [2*NBIN];
  logic [31:0] bank2 [2*NBIN];

  logic       wptr1_q, wptr2_q;
  logic       done1_q, done1_d, done2_q, done2_d;
  logic       busy_q, busy_d;
  logic       pend_q, pend_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] rbank_q, rbank_d;
  logic [1:0] pbank_q, pbank_d;
  logic       clr_done;
  logic       fin1, fin2;

  assign fin1 = fft1_valid & fft1_fin;
  assign fin2 = fft2_valid & fft2_fin;

  always_ff @(posedge clk) begin
    if (fft1_valid) bank1[{wptr1_q, freq1}] <= fft1_data;
    if (fft2_valid) bank2[{wptr2_q, freq2}] <= fft2_data;
  end

  // A frame finishing on the same edge as a new start may immediately chain into the next.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rbank_d  = rbank_q;
    pend_d   = pend_q;
    pbank_d  = pbank_q;
    clr_done = 1'b0;
    if (busy_q) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LastBin) begin
        if (pend_q) begin
          cnt_d   = 6'd0;
          rbank_d = pbank_q;
          pend_d  = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
    end
    if (done1_q && done2_q) begin
      clr_done = 1'b1;
      if (!busy_d) begin
        busy_d  = 1'b1;
        cnt_d   = 6'd0;
        rbank_d = {~wptr2_q, ~wptr1_q};
      end else if (!pend_d) begin
        pend_d  = 1'b1;
        pbank_d = {~wptr2_q, ~wptr1_q};
      end
    end
  end

  assign done1_d = fin1 | (done1_q & ~clr_done);
  assign done2_d = fin2 | (done2_q & ~clr_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr1_q <= 1'b0;
      wptr2_q <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= 6'd0;
      rbank_q <= 2'b00;
      pbank_q <= 2'b00;
    end else begin
      wptr1_q <= wptr1_q ^ fin1;
      wptr2_q <= wptr2_q ^ fin2;
      done1_q <= done1_d;
      done2_q <= done2_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rbank_q <= rbank_d;
      pbank_q <= pbank_d;
    end
  end

  logic [5:0]  src_bin;
  logic [31:0] a, b;
  logic [16:0] sum_re, sum_im;
  logic [15:0] avg_re, avg_im;
  logic [31:0] result;

  always_comb begin
    src_bin = cnt_q - ShiftBins;
    a       = bank1[{rbank_q[0], src_bin}];
    b       = bank2[{rbank_q[1], src_bin}];
    sum_re  = {a[31], a[31:16]} + {b[31], b[31:16]};
    sum_im  = {a[15], a[15:0]} + {b[15], b[15:0]};
    // Dropping the LSB of the 17-bit sum is an arithmetic shift: rounds toward -inf.
    avg_re  = 16'(sum_re >> 1);
    avg_im  = 16'(sum_im >> 1);
    result  = (cnt_q < ShiftBins) ? 32'd0 : {avg_re, avg_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raise_data  <= 32'd0;
      raise_valid <= 1'b0;
      freq_out    <= 6'd0;
      raise_fin   <= 1'b0;
    end else if (busy_q) begin
      raise_data  <= result;
      raise_valid <= 1'b1;
      freq_out    <= cnt_q;
      raise_fin   <= (cnt_q == LastBin);
    end else begin
      raise_valid <= 1'b0;
      raise_fin   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raise_freq.sv
// Scoreboard bench for raise_freq: a frame-level model queues expected bins and their
// arrival edges; a negedge monitor pops and compares whatever the DUT emits.
module tb_raise_freq;

  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fft1_data, fft2_data;
  logic        fft1_valid, fft2_valid;
  logic [5:0]  freq1, freq2;
  logic        fft1_fin, fft2_fin;
  logic [31:0] raise_data;
  logic        raise_valid;
  logic [5:0]  freq_out;
  logic        raise_fin;

  always #5 clk = ~clk;

  raise_freq #(.SHIFT(SHIFT), .NBIN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .fft1_data  (fft1_data),
    .fft1_valid (fft1_valid),
    .freq1      (freq1),
    .fft1_fin   (fft1_fin),
    .fft2_data  (fft2_data),
    .fft2_valid (fft2_valid),
    .freq2      (freq2),
    .fft2_fin   (fft2_fin),
    .raise_data (raise_data),
    .raise_valid(raise_valid),
    .freq_out   (freq_out),
    .raise_fin  (raise_fin)
  );

  typedef logic [31:0] frame_t [64];
  typedef struct {
    logic [31:0] data;
    logic [5:0]  freq;
    logic        fin;
    int          at_edge;
  } exp_t;

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     edge_cnt = 0;

  frame_t fr1, fr2, cur1, cur2, dn1_fr, dn2_fr;
  bit     dn1 = 0, dn2 = 0;
  int     dn1_e, dn2_e;
  int     last_out = -100;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [15:0] avg16(input logic [15:0] x, input logic [15:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    s = s >>> 1;
    return 16'(s);
  endfunction

  // Frame-level reference: once both channels hold a completed frame, emit the shifted average.
  task automatic model_update();
    int   first;
    exp_t e;
    if (fft1_valid) cur1[freq1] = fft1_data;
    if (fft2_valid) cur2[freq2] = fft2_data;
    if (fft1_valid && fft1_fin) begin dn1_fr = cur1; dn1 = 1; dn1_e = edge_cnt; end
    if (fft2_valid && fft2_fin) begin dn2_fr = cur2; dn2 = 1; dn2_e = edge_cnt; end
    if (dn1 && dn2) begin
      first = ((dn1_e > dn2_e) ? dn1_e : dn2_e) + 2;
      if (last_out + 1 > first) first = last_out + 1;
      for (int k = 0; k < 64; k++) begin
        if (k < SHIFT) e.data = 32'd0;
        else e.data = {avg16(dn1_fr[k-SHIFT][31:16], dn2_fr[k-SHIFT][31:16]),
                       avg16(dn1_fr[k-SHIFT][15:0],  dn2_fr[k-SHIFT][15:0])};
        e.freq    = 6'(k);
        e.fin     = (k == 63);
        e.at_edge = first + k;
        exp_q.push_back(e);
      end
      last_out = first + 63;
      dn1 = 0;
      dn2 = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) model_update();
  endtask

  task automatic idle_inputs();
    fft1_valid = 0; fft1_fin = 0; freq1 = 0; fft1_data = 0;
    fft2_valid = 0; fft2_fin = 0; freq2 = 0; fft2_data = 0;
  endtask

  task automatic send_frames(input int skew);
    for (int c = 0; c < 64 + skew; c++) begin
      idle_inputs();
      if (c < 64) begin
        fft1_valid = 1; freq1 = 6'(c); fft1_data = fr1[c]; fft1_fin = (c == 63);
      end
      if (c >= skew && c - skew < 64) begin
        fft2_valid = 1; freq2 = 6'(c - skew); fft2_data = fr2[c-skew]; fft2_fin = (c - skew == 63);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bins outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 64; i++) begin fr1[i] = v; fr2[i] = v; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin fr1[i] = $urandom(); fr2[i] = $urandom(); end
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && raise_valid) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid: freq %0d data %h at edge %0d, expected no output",
                     freq_out, raise_data, edge_cnt);
          end else begin
            e = exp_q.pop_front();
            if (raise_data !== e.data || freq_out !== e.freq || raise_fin !== e.fin ||
                edge_cnt != e.at_edge) begin
              miscompares++;
              $display("FAIL bin: got data %h freq %0d fin %b edge %0d, expected %h %0d %b %0d",
                       raise_data, freq_out, raise_fin, edge_cnt,
                       e.data, e.freq, e.fin, e.at_edge);
            end
          end
        end else if (!rst && exp_q.size() != 0 && exp_q[0].at_edge <= edge_cnt) begin
          vectors++;
          miscompares++;
          e = exp_q.pop_front();
          $display("FAIL missing_bin: no valid at edge %0d, expected freq %0d data %h",
                   edge_cnt, e.freq, e.data);
        end
      end
    join_none

    idle_inputs();
    rst = 1;
    #1;
    chk("reset_data", raise_data, 32'd0);
    chk("reset_valid", {31'd0, raise_valid}, 32'd0);
    chk("reset_freq", {26'd0, freq_out}, 32'd0);
    chk("reset_fin", {31'd0, raise_fin}, 32'd0);
    tick();
    tick();
    chk("reset_valid_held", {31'd0, raise_valid}, 32'd0);
    rst = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("idle_after_reset", {31'd0, raise_valid}, 32'd0);

    // Impulse at bin 10 lands at k=14 as 0x0200_0000.
    fill_const(32'd0);
    fr1[10] = 32'h0100_0080;
    fr2[10] = 32'h0300_FF80;
    send_frames(0);
    drain();

    fill_const(32'h7FFF_8000);
    send_frames(0);
    drain();

    fill_const(32'd0);
    fr1[0] = 32'h0001_FFFF;
    send_frames(0);
    drain();

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 64; i++) begin fr1[i] = 32'(f * 64 + i); fr2[i] = 32'(f * 64 + i); end
      send_frames(0);
    end
    drain();

    fill_rand();
    send_frames(5);
    drain();

    // Reset while a frame is streaming out.
    fill_rand();
    send_frames(5);
    for (int i = 0; i < 10 && !raise_valid; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("midreset_valid", {31'd0, raise_valid}, 32'd0);
    chk("midreset_fin", {31'd0, raise_fin}, 32'd0);
    exp_q.delete();
    dn1 = 0;
    dn2 = 0;
    last_out = -100;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_reset_idle", {31'd0, raise_valid}, 32'd0);
    fill_rand();
    send_frames(0);
    fill_rand();
    send_frames(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/raise_freq.md
Name: raise_freq

Overview:
- Frequency-domain pitch-raise stage of the voice transformer.
- Takes two 64-bin FFT frame streams (two overlapped analysis channels). Each bin is complex, packed as a 16-bit real and a 16-bit imaginary part.
- Shifts each spectrum up by SHIFT bins and averages the two channels.
- Emits one 64-bin output frame per input frame pair, for the downstream IFFT.

Parameters:
- SHIFT, 4, number of bins the spectrum is moved upward (0..63).
- NBIN, 64, bins per frame (fixed; the 6-bit freq fields depend on it).

Ports:
- clk, in, 1, single system clock; all logic on the rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- fft1_data, in, 32, channel 1 bin: [31:16] signed real, [15:0] signed imaginary.
- fft1_valid, in, 1, fft1_data/freq1/fft1_fin are valid this cycle.
- freq1, in, 6, bin index of fft1_data.
- fft1_fin, in, 1, last bin of the channel 1 frame (accompanies bin 63).
- fft2_data, fft2_valid, freq2, fft2_fin: same as the channel 1 ports, for channel 2.
- raise_data, out, 32, output bin: [31:16] real, [15:0] imaginary, signed.
- raise_valid, out, 1, raise_data/freq_out valid.
- freq_out, out, 6, bin index of raise_data.
- raise_fin, out, 1, high with output bin 63.

Behaviour:
- Reset (async, rst=1): raise_data=0, raise_valid=0, freq_out=0, raise_fin=0. Done flags, pending flag, bank pointers and counters are cleared. Bin memories are not cleared.
- Storage: per channel, two 64x32 banks (ping-pong).
  - On a rising edge with fftN_valid=1, fftN_data is written to the current write bank at address freqN.
  - On fftN_valid=1 with fftN_fin=1: the bin is written, the channel's write bank toggles, and doneN is set.
  - fin with valid=0 is ignored.
- Start condition: done1 && done2, tested after the fin writes land.
  - If idle, output of the just-completed banks starts; done1/done2 are cleared.
  - If busy, a single pending flag is set and output starts in the cycle after the current frame's last bin.
  - A further completion while pending is already set is dropped.
- Channels may finish on different cycles; output waits for both.
- Output sequence: bins k=0..63, one per clock, no gaps.
  - raise_valid=1 for exactly 64 consecutive cycles; freq_out=k.
  - raise_fin=1 only when k=63.
  - First output bin appears at the second rising edge after the edge that captured the completing fin.
- Arithmetic per output bin k:
  - k < SHIFT: raise_data = 0.
  - Otherwise a = bank1[k-SHIFT] and b = bank2[k-SHIFT].
  - Real part = (a.re + b.re) computed in 17-bit signed, then arithmetic right shift by 1 (rounds toward minus infinity). Imaginary part is computed the same way.
  - No overflow is possible.
  - Bins k-SHIFT that were never written in the frame read stale memory contents; this is allowed.
- Throughput: sustains continuous input of 64 bins per 64 cycles per channel. Input writes never target the banks being read.
- When idle: raise_valid=0, raise_fin=0; raise_data and freq_out hold their last values.
- Reset mid-frame: output stops immediately and the partial input frame is discarded.

Test Plan:
- Reset check: assert rst for 2 cycles -> all outputs 0, no raise_valid during or after, until two complete frames arrive.
- Single frame, impulse: fft1 bin 10 = 0x0100_0080, fft2 bin 10 = 0x0300_FF80, all other bins 0, SHIFT=4 -> exactly 64 valid outputs. freq_out = 0..63 and raise_fin only at 63. raise_data = 0x0200_0000 at k=14; all other k = 0.
- Low-bin zero fill: all input bins 0x7FFF_8000 on both channels -> k=0..3 output 0x0000_0000; k=4..63 output 0x7FFF_8000.
- Rounding: fft1 bin 0 = 0x0001_FFFF, fft2 bin 0 = 0x0000_0000 -> k=4 output 0x0000_FFFF (1>>1=0, -1>>1=-1).
- Continuous stream: 8 back-to-back frames, freq 0..63 repeating, fin on bin 63, with ramp data (bin value = frame*64+bin on both channels) -> 8 output frames with no idle cycle between them. Each output frame equals the ramp of its own input frame shifted by 4, with no bank cross-contamination.
- Skewed fins: channel 2's frame is delayed 5 cycles relative to channel 1 -> output starts 2 edges after fft2_fin, with correct data. A reset asserted during output clears raise_valid at once, and output resumes only after two new complete frames.
